mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one multiplier (2..8).
REQ-002 SHALL have parameter DATAWIDTH_IN, default 32, operand width.
REQ-003 SHALL have parameter DATAWIDTH_OUT, default 60, multiplier result width.
REQ-004 SHALL have parameter MUL_LATENCY, default 1, multiplier cycles from operand valid to result valid (1..8).
REQ-005 SHALL have port aclk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port aresetn  input  1  reset; synchronous, active-low.
REQ-007 SHALL have port issue_en  input  1  high permits issuing operations.
REQ-008 SHALL have port s_req_tvalid  input  NUM_REQ  per-requester operand-pair valid.
REQ-009 SHALL have port s_req_tready  output  NUM_REQ  per-requester grant; handshake = tvalid & tready.
REQ-010 SHALL have port s_req_a_tdata  input  NUM_REQ*DATAWIDTH_IN  packed operand A; requester i at [i*DATAWIDTH_IN +: DATAWIDTH_IN].
REQ-011 SHALL have port s_req_b_tdata  input  NUM_REQ*DATAWIDTH_IN  packed operand B, same packing.
REQ-012 SHALL have ports m_mul_a_tvalid, m_mul_b_tvalid  output  1  operand valids to multiplier; always equal.
REQ-013 SHALL have ports m_mul_a_tdata, m_mul_b_tdata  output  DATAWIDTH_IN  operands to multiplier.
REQ-014 SHALL have port s_mul_result_tvalid  input  1  multiplier result valid.
REQ-015 SHALL have port s_mul_result_tdata  input  DATAWIDTH_OUT  multiplier result.
REQ-016 SHALL have port m_res_tvalid  output  NUM_REQ  one-hot result-valid to owning requester.
REQ-017 SHALL have port m_res_tdata  output  DATAWIDTH_OUT  shared result bus.
REQ-018 SHALL have port busy  output  1  high while any operation is in flight.
REQ-019 SHALL have port err_flags  output  2  sticky: [0] orphan result, [1] missing result.

Function
REQ-020 SHALL grant at most one requester per cycle, combinationally from s_req_tvalid, issue_en and the round-robin pointer; s_req_tready all-zero when issue_en low.
REQ-021 SHALL search from pointer ptr upward modulo NUM_REQ; first valid requester wins; on a handshake by requester g, ptr <= (g+1) mod NUM_REQ; otherwise ptr holds.
REQ-022 SHALL register the winner's operands onto m_mul_*_tdata with m_mul_*_tvalid=1 one cycle after the handshake; m_mul_*_tvalid=0 and operand data 0 in cycles with no handshake.
REQ-023 SHALL track each issued operation in a tag shift pipeline {valid, id} of depth MUL_LATENCY, advancing every cycle, aligned with s_mul_result_tvalid.
REQ-024 SHALL, when s_mul_result_tvalid=1 and pipeline-tail valid=1, register m_res_tvalid = one-hot(tail id) and m_res_tdata = s_mul_result_tdata one cycle later; total latency handshake-to-result = MUL_LATENCY+2 cycles.
REQ-025 SHALL drive m_res_tvalid all-zero and hold m_res_tdata otherwise; results carry no backpressure.
REQ-026 SHALL set err_flags[0] when s_mul_result_tvalid=1 with tail valid=0 (result dropped), and err_flags[1] when tail valid=1 with s_mul_result_tvalid=0 (no result delivered).
REQ-027 SHALL drive busy high when the operand register or any tag-pipeline stage holds a valid entry.
REQ-028 SHALL sustain one issue per cycle back-to-back; requester kept high alone is granted every cycle.
REQ-029 SHALL, when issue_en drops, complete all in-flight operations normally.

Reset
REQ-030 SHALL, with aresetn=0 at a clock edge: ptr=0, tag pipeline and operand register cleared, m_mul_*_tvalid=0, m_mul_*_tdata=0, m_res_tvalid=0, m_res_tdata=0, busy=0, err_flags=0, s_req_tready=0.
REQ-031 SHALL discard in-flight operations on reset mid-operation; results arriving after reset release with no tag SHALL set err_flags[0] only.

Configuration
REQ-032 SHALL, with macro MUL_ARBITER_STATS_EN defined, add output stat_issue_count (NUM_REQ*16 bits, per-requester issue counters, saturating at 16'hFFFF, cleared by reset); without it the port and counters SHALL not exist and behaviour is otherwise identical.

Verification
REQ-033 SHALL test all 4 requesters valid continuously, issue_en=1 -> grants 0,1,2,3,0,... one per cycle, each result to correct requester.
REQ-034 SHALL test requester 2 alone, A=3, B=5, MUL_LATENCY=1 with model -> m_res_tvalid=4'b0100, m_res_tdata=15 three cycles after handshake.
REQ-035 SHALL test issue_en=0 with requests pending -> s_req_tready=0 and no m_mul_a_tvalid; busy falls after in-flight drain.
REQ-036 SHALL test injected s_mul_result_tvalid with no issue -> err_flags=2'b01, sticky until reset.
REQ-037 SHALL test aresetn low one cycle during 3 in-flight ops -> all outputs zero, no m_res_tvalid from those ops.
REQ-038 SHALL test with MUL_ARBITER_STATS_EN, 10 issues from requester 1 -> stat_issue_count[31:16]=10, others 0.

Source files
------------

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NUM_REQ requesters.
// Optional macro MUL_ARBITER_STATS_EN adds per-requester saturating issue counters.
module mul_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATAWIDTH_IN  = 32,
    parameter int DATAWIDTH_OUT = 60,
    parameter int MUL_LATENCY   = 1
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            issue_en,
    input  logic [NUM_REQ-1:0]              s_req_tvalid,
    output logic [NUM_REQ-1:0]              s_req_tready,
    input  logic [NUM_REQ*DATAWIDTH_IN-1:0] s_req_a_tdata,
    input  logic [NUM_REQ*DATAWIDTH_IN-1:0] s_req_b_tdata,
    output logic                            m_mul_a_tvalid,
    output logic                            m_mul_b_tvalid,
    output logic [DATAWIDTH_IN-1:0]         m_mul_a_tdata,
    output logic [DATAWIDTH_IN-1:0]         m_mul_b_tdata,
    input  logic                            s_mul_result_tvalid,
    input  logic [DATAWIDTH_OUT-1:0]        s_mul_result_tdata,
    output logic [NUM_REQ-1:0]              m_res_tvalid,
    output logic [DATAWIDTH_OUT-1:0]        m_res_tdata,
    output logic                            busy,
    output logic [1:0]                      err_flags
`ifdef MUL_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]           stat_issue_count
`endif
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    logic [IDW-1:0]             ptr;
    logic [IDW-1:0]             grant_id;
    logic [IDW-1:0]             idx;
    logic [NUM_REQ-1:0]         grant;
    logic                       found;
    logic                       hs;
    logic                       op_vld;
    logic [IDW-1:0]             op_id;
    tag_t [MUL_LATENCY-1:0]     tag_pipe;
    tag_t                       tail;

    // Search upward from ptr; reset also blocks grants so nothing is accepted
    // while the pipeline is being cleared.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        idx      = '0;
        found    = 1'b0;
        if (issue_en && aresetn) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = IDW'((int'(ptr) + k) % NUM_REQ);
                if (!found && s_req_tvalid[idx]) begin
                    found       = 1'b1;
                    grant[idx]  = 1'b1;
                    grant_id    = idx;
                end
            end
        end
    end

    assign s_req_tready = grant;
    assign hs           = |(s_req_tvalid & grant);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ptr           <= '0;
            op_vld        <= 1'b0;
            op_id         <= '0;
            m_mul_a_tdata <= '0;
            m_mul_b_tdata <= '0;
        end else if (hs) begin
            ptr           <= IDW'((int'(grant_id) + 1) % NUM_REQ);
            op_vld        <= 1'b1;
            op_id         <= grant_id;
            m_mul_a_tdata <= s_req_a_tdata[int'(grant_id)*DATAWIDTH_IN +: DATAWIDTH_IN];
            m_mul_b_tdata <= s_req_b_tdata[int'(grant_id)*DATAWIDTH_IN +: DATAWIDTH_IN];
        end else begin
            op_vld        <= 1'b0;
            op_id         <= '0;
            m_mul_a_tdata <= '0;
            m_mul_b_tdata <= '0;
        end
    end

    assign m_mul_a_tvalid = op_vld;
    assign m_mul_b_tvalid = op_vld;

    // Tag pipeline mirrors the multiplier latency so the tail lines up with its result.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= '{vld: op_vld, id: op_id};
            for (int i = 1; i < MUL_LATENCY; i++)
                tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign tail = tag_pipe[MUL_LATENCY-1];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_res_tvalid <= '0;
            m_res_tdata  <= '0;
            err_flags    <= '0;
        end else begin
            m_res_tvalid <= '0;
            if (s_mul_result_tvalid && tail.vld) begin
                m_res_tvalid <= NUM_REQ'(1) << tail.id;
                m_res_tdata  <= s_mul_result_tdata;
            end
            err_flags[0] <= err_flags[0] | (s_mul_result_tvalid & ~tail.vld);
            err_flags[1] <= err_flags[1] | (~s_mul_result_tvalid & tail.vld);
        end
    end

    always_comb begin
        busy = op_vld;
        for (int i = 0; i < MUL_LATENCY; i++)
            busy = busy | tag_pipe[i].vld;
    end

`ifdef MUL_ARBITER_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        logic [15:0] cnt;
        always_ff @(posedge aclk) begin
            if (!aresetn)
                cnt <= '0;
            else if (hs && grant[g] && cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;
        end
        assign stat_issue_count[g*16 +: 16] = cnt;
    end
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: table vectors, directed corner sequences and random traffic
// checked against a cycle-indexed expectation model plus a behavioural multiplier.
module tb_mul_arbiter;
    localparam int NR   = 4;
    localparam int DW   = 32;
    localparam int DO   = 60;
    localparam int LAT  = 1;
    localparam int MAXC = 1024;

    logic               aclk = 1'b0;
    logic               aresetn = 1'b0;
    logic               issue_en = 1'b0;
    logic [NR-1:0]      s_req_tvalid = '0;
    logic [NR-1:0]      s_req_tready;
    logic [NR*DW-1:0]   a_d = '0;
    logic [NR*DW-1:0]   b_d = '0;
    logic               m_mul_a_tvalid, m_mul_b_tvalid;
    logic [DW-1:0]      m_mul_a_tdata, m_mul_b_tdata;
    logic               s_mul_result_tvalid;
    logic [DO-1:0]      s_mul_result_tdata;
    logic [NR-1:0]      m_res_tvalid;
    logic [DO-1:0]      m_res_tdata;
    logic               busy;
    logic [1:0]         err_flags;
`ifdef MUL_ARBITER_STATS_EN
    logic [NR*16-1:0]   stat_issue_count;
`endif

    mul_arbiter #(.NUM_REQ(NR), .DATAWIDTH_IN(DW), .DATAWIDTH_OUT(DO), .MUL_LATENCY(LAT)) dut (
        .aclk(aclk), .aresetn(aresetn), .issue_en(issue_en),
        .s_req_tvalid(s_req_tvalid), .s_req_tready(s_req_tready),
        .s_req_a_tdata(a_d), .s_req_b_tdata(b_d),
        .m_mul_a_tvalid(m_mul_a_tvalid), .m_mul_b_tvalid(m_mul_b_tvalid),
        .m_mul_a_tdata(m_mul_a_tdata), .m_mul_b_tdata(m_mul_b_tdata),
        .s_mul_result_tvalid(s_mul_result_tvalid), .s_mul_result_tdata(s_mul_result_tdata),
        .m_res_tvalid(m_res_tvalid), .m_res_tdata(m_res_tdata),
        .busy(busy), .err_flags(err_flags)
`ifdef MUL_ARBITER_STATS_EN
        , .stat_issue_count(stat_issue_count)
`endif
    );

    always #5 aclk = ~aclk;

    // Behavioural multiplier with fault-injection hooks (not reset, like a real core).
    bit            inj = 1'b0;
    bit            drop = 1'b0;
    logic [DO-1:0] inj_data = '0;
    logic          mv_pipe [LAT];
    logic [DO-1:0] md_pipe [LAT];
    logic [63:0]   prod;
    assign prod = {32'b0, m_mul_a_tdata} * {32'b0, m_mul_b_tdata};
    always @(posedge aclk) begin
        mv_pipe[0] <= m_mul_a_tvalid;
        md_pipe[0] <= prod[DO-1:0];
        for (int i = 1; i < LAT; i++) begin
            mv_pipe[i] <= mv_pipe[i-1];
            md_pipe[i] <= md_pipe[i-1];
        end
    end
    assign s_mul_result_tvalid = (mv_pipe[LAT-1] & ~drop) | inj;
    assign s_mul_result_tdata  = inj ? inj_data : md_pipe[LAT-1];

    // Expectations indexed by cycle number.
    bit            exp_mv   [MAXC];
    logic [DW-1:0] exp_ma   [MAXC];
    logic [DW-1:0] exp_mb   [MAXC];
    bit            exp_mres [MAXC];
    logic [DO-1:0] exp_mdat [MAXC];
    bit            exp_tail [MAXC];
    int            exp_tid  [MAXC];
    int            exp_rid  [MAXC];
    logic [DO-1:0] exp_rdat [MAXC];
    int            cyc, mptr, n_cmp, n_bad;
    logic [1:0]    exp_err;
    logic [DO-1:0] hold;
    int            cnt [NR];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input logic [NR-1:0] tv, input logic en, input logic rn,
                        input bit rnd, output logic [NR-1:0] rdy);
        bit          b, resv;
        int          g;
        logic [63:0] p;
        logic [1:0]  pend, err_n;
        if (exp_rid[cyc] >= 0) hold = exp_rdat[cyc];
        chk("m_mul_a_tvalid", 64'(m_mul_a_tvalid), 64'(exp_mv[cyc]));
        chk("m_mul_b_tvalid", 64'(m_mul_b_tvalid), 64'(exp_mv[cyc]));
        chk("m_mul_a_tdata", 64'(m_mul_a_tdata), exp_mv[cyc] ? 64'(exp_ma[cyc]) : 64'd0);
        chk("m_mul_b_tdata", 64'(m_mul_b_tdata), exp_mv[cyc] ? 64'(exp_mb[cyc]) : 64'd0);
        chk("m_res_tvalid", 64'(m_res_tvalid), exp_rid[cyc] >= 0 ? 64'd1 << exp_rid[cyc] : 64'd0);
        chk("m_res_tdata", 64'(m_res_tdata), 64'(hold));
        b = exp_mv[cyc];
        for (int k = 0; k < LAT; k++) b |= exp_tail[cyc+k];
        chk("busy", 64'(busy), 64'(b));
        chk("err_flags", 64'(err_flags), 64'(exp_err));

        s_req_tvalid = tv;
        issue_en     = en;
        aresetn      = rn;
        if (rnd) for (int i = 0; i < NR; i++) begin
            a_d[i*DW +: DW] = $urandom;
            b_d[i*DW +: DW] = $urandom;
        end
        #1;
        rdy = s_req_tready;
        g = -1;
        if (en && rn)
            for (int k = 0; k < NR; k++)
                if (g < 0 && tv[(mptr+k)%NR]) g = (mptr+k)%NR;
        chk("s_req_tready", 64'(s_req_tready), g >= 0 ? 64'd1 << g : 64'd0);

        pend = 2'b00;
        if (rn) begin
            if (g >= 0) begin
                mptr = (g + 1) % NR;
                cnt[g]++;
                exp_mv[cyc+1] = 1'b1;
                exp_ma[cyc+1] = a_d[g*DW +: DW];
                exp_mb[cyc+1] = b_d[g*DW +: DW];
                p = {32'b0, a_d[g*DW +: DW]} * {32'b0, b_d[g*DW +: DW]};
                exp_mres[cyc+1+LAT] = 1'b1;
                exp_mdat[cyc+1+LAT] = p[DO-1:0];
                exp_tail[cyc+1+LAT] = 1'b1;
                exp_tid[cyc+1+LAT]  = g;
            end
            resv = (exp_mres[cyc] && !drop) || inj;
            if (resv && exp_tail[cyc]) begin
                exp_rid[cyc+1]  = exp_tid[cyc];
                exp_rdat[cyc+1] = inj ? inj_data : exp_mdat[cyc];
            end
            if (resv && !exp_tail[cyc]) pend[0] = 1'b1;
            if (!resv && exp_tail[cyc]) pend[1] = 1'b1;
            err_n = exp_err | pend;
        end else begin
            // Everything the design holds is discarded; the multiplier itself keeps going.
            for (int c = cyc + 1; c < MAXC; c++) begin
                exp_mv[c]   = 1'b0;
                exp_tail[c] = 1'b0;
                exp_rid[c]  = -1;
            end
            mptr  = 0;
            hold  = '0;
            err_n = 2'b00;
            for (int i = 0; i < NR; i++) cnt[i] = 0;
        end
        @(negedge aclk);
        cyc++;
        exp_err = err_n;
    endtask

    typedef struct {
        logic [NR-1:0] tv;
        logic          en;
        logic [NR-1:0] rdy;
    } vec_t;
    vec_t tbl [11];

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] rdy;
        n_cmp = 0; n_bad = 0; mptr = 0; exp_err = '0; hold = '0;
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        for (int c = 0; c < MAXC; c++) begin
            exp_mv[c] = 0; exp_ma[c] = '0; exp_mb[c] = '0; exp_mres[c] = 0;
            exp_mdat[c] = '0; exp_tail[c] = 0; exp_tid[c] = 0; exp_rid[c] = -1; exp_rdat[c] = '0;
        end
        repeat (2) @(negedge aclk);
        cyc = 0;

        // Round-robin vectors from ptr=0, one row per cycle.
        tbl[0]  = '{4'b0000, 1'b1, 4'b0000};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0000};
        tbl[2]  = '{4'b0100, 1'b1, 4'b0100};
        tbl[3]  = '{4'b0011, 1'b1, 4'b0001};
        tbl[4]  = '{4'b0011, 1'b1, 4'b0010};
        tbl[5]  = '{4'b1001, 1'b1, 4'b1000};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0001};
        tbl[7]  = '{4'b1101, 1'b1, 4'b0100};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0000};
        tbl[9]  = '{4'b0001, 1'b0, 4'b0000};
        tbl[10] = '{4'b1000, 1'b1, 4'b1000};

        step('0, 1'b0, 1'b1, 1'b1, rdy);   // reset-state outputs checked here
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].tv, tbl[i].en, 1'b1, 1'b1, rdy);
            chk("tbl_grant", 64'(rdy), 64'(tbl[i].rdy));
        end

        // All requesters continuously valid: 0,1,2,3,0,...
        for (int k = 0; k < 12; k++) begin
            step(4'hF, 1'b1, 1'b1, 1'b1, rdy);
            chk("rr_grant", 64'(rdy), 64'd1 << (k % 4));
        end
        repeat (3) step('0, 1'b1, 1'b1, 1'b1, rdy);

        // Requester 2 alone, 3*5 lands three cycles after the handshake.
        a_d[2*DW +: DW] = 32'd3;
        b_d[2*DW +: DW] = 32'd5;
        step(4'b0100, 1'b1, 1'b1, 1'b0, rdy);
        repeat (2) step('0, 1'b1, 1'b1, 1'b1, rdy);
        chk("single_res_vld", 64'(m_res_tvalid), 64'b0100);
        chk("single_res_dat", 64'(m_res_tdata), 64'd15);

        // issue_en low with requests pending; in-flight op drains.
        step(4'hF, 1'b1, 1'b1, 1'b1, rdy);
        repeat (6) step(4'hF, 1'b0, 1'b1, 1'b1, rdy);
        chk("gated_busy", 64'(busy), 64'd0);
        chk("gated_mul_vld", 64'(m_mul_a_tvalid), 64'd0);

        for (int k = 0; k < 300; k++)
            step(NR'($urandom_range(0, 15)), ($urandom_range(0, 9) != 0), 1'b1, 1'b1, rdy);
        repeat (4) step('0, 1'b1, 1'b1, 1'b1, rdy);

        // Orphan result: sticky until reset.
        inj = 1'b1; inj_data = DO'(64'h123);
        step('0, 1'b1, 1'b1, 1'b1, rdy);
        inj = 1'b0;
        repeat (4) step('0, 1'b1, 1'b1, 1'b1, rdy);
        chk("orphan_sticky", 64'(err_flags), 64'b01);
        step('0, 1'b1, 1'b0, 1'b1, rdy);
        step('0, 1'b1, 1'b1, 1'b1, rdy);
        chk("orphan_cleared", 64'(err_flags), 64'b00);

        // Missing result: multiplier swallows one answer.
        step(4'b0010, 1'b1, 1'b1, 1'b1, rdy);
        step('0, 1'b1, 1'b1, 1'b1, rdy);
        drop = 1'b1;
        step('0, 1'b1, 1'b1, 1'b1, rdy);
        drop = 1'b0;
        repeat (3) step('0, 1'b1, 1'b1, 1'b1, rdy);
        chk("missing_sticky", 64'(err_flags), 64'b10);
        step('0, 1'b1, 1'b0, 1'b1, rdy);

        // Reset during three in-flight ops.
        repeat (3) step(4'hF, 1'b1, 1'b1, 1'b1, rdy);
        step('0, 1'b1, 1'b0, 1'b1, rdy);
        chk("rst_mul_vld", 64'(m_mul_a_tvalid), 64'd0);
        chk("rst_mul_dat", 64'(m_mul_a_tdata), 64'd0);
        chk("rst_res_vld", 64'(m_res_tvalid), 64'd0);
        chk("rst_res_dat", 64'(m_res_tdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err_flags), 64'd0);
        repeat (4) step('0, 1'b1, 1'b1, 1'b1, rdy);
        chk("rst_orphan", 64'(err_flags), 64'b01);

        // Ten issues from requester 1 after a fresh reset.
        step('0, 1'b1, 1'b0, 1'b1, rdy);
        repeat (10) step(4'b0010, 1'b1, 1'b1, 1'b1, rdy);
        repeat (4) step('0, 1'b1, 1'b1, 1'b1, rdy);
`ifdef MUL_ARBITER_STATS_EN
        chk("stat_req1", 64'(stat_issue_count[31:16]), 64'd10);
        for (int i = 0; i < NR; i++)
            chk("stat_count", 64'(stat_issue_count[i*16 +: 16]), 64'(cnt[i]));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
